// File: rtl/digital_tube.sv
// 8-digit multiplexed hex display driver with byte-enabled DATA and CTRL registers.
// Latency: TubeSel/TubeSeg lag scan/register state by one cycle; writes always accepted, no backpressure.
module digital_tube #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WE,
  input  logic        Addr,
  input  logic [3:0]  BE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic [7:0]  TubeSel,
  output logic [7:0]  TubeSeg
);

  localparam logic [DIV_W-1:0] PC_LAST = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] pc_q, pc_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic [3:0]       nibble;
  logic             upper_zero;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (WE && !Addr) begin
      for (int k = 0; k < 4; k++) begin
        if (BE[k]) data_d[8*k +: 8] = DIn[8*k +: 8];
      end
    end
    if (WE && Addr && BE[0]) ctrl_d = DIn[1:0];
  end

  // Scan timing is free-running and never touched by bus traffic.
  always_comb begin
    tick  = (pc_q == PC_LAST);
    pc_d  = tick ? '0 : pc_q + DIV_W'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;
  end

  always_comb begin
    nibble     = data_q[{idx_q, 2'b00} +: 4];
    upper_zero = ((data_q >> {idx_q, 2'b00}) == 32'd0);
    sel_d      = 8'hFF;
    seg_d      = 8'hFF;
    if (ctrl_q[0]) begin
      sel_d = ~(8'd1 << idx_q);
      // Digit 0 always shows, so an all-zero value still reads as "0".
      if (!(ctrl_q[1] && (idx_q != 3'd0) && upper_zero)) seg_d = hex_seg(nibble);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q <= 32'd0;
      ctrl_q <= 2'b01;
      pc_q   <= '0;
      idx_q  <= 3'd0;
      sel_q  <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  assign DOut    = Addr ? {30'd0, ctrl_q} : data_q;
  assign TubeSel = sel_q;
  assign TubeSeg = seg_q;

endmodule

// File: tb/tb_digital_tube.sv
// Randomized and directed bench for digital_tube against a cycle-count based display model.
module tb_digital_tube;

  localparam int SCAN_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0;
  logic        Addr = 1'b0;
  logic [3:0]  BE = 4'h0;
  logic [31:0] DIn = 32'd0;
  logic [31:0] DOut;
  logic [7:0]  TubeSel;
  logic [7:0]  TubeSeg;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_data;
  logic [1:0]  m_ctrl;
  int          m_cyc;
  logic [7:0]  exp_sel;
  logic [7:0]  exp_seg;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  digital_tube #(.SCAN_DIV(SCAN_DIV), .DIV_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .WE(WE), .Addr(Addr), .BE(BE), .DIn(DIn),
    .DOut(DOut), .TubeSel(TubeSel), .TubeSeg(TubeSeg)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] model_seg(input logic [31:0] d, input logic [1:0] c, input int idx);
    longint unsigned dd;
    longint unsigned upper;
    dd = 64'(d);
    upper = dd / (64'd1 << (4 * idx));
    if (!c[0]) return 8'hFF;
    if (c[1] && idx != 0 && upper == 0) return 8'hFF;
    return seg_tbl[int'(upper % 16)];
  endfunction

  task automatic model_reset();
    m_data = 32'd0;
    m_ctrl = 2'b01;
    m_cyc  = 0;
  endtask

  // One clock edge; the expectation is formed from the model state before the edge.
  task automatic clk_cycle(input bit we, input bit addr, input logic [3:0] be, input logic [31:0] din);
    int idx;
    WE = we; Addr = addr; BE = be; DIn = din;
    @(posedge Clk);
    idx = (m_cyc / SCAN_DIV) % 8;
    exp_sel = m_ctrl[0] ? ~(8'd1 << idx) : 8'hFF;
    exp_seg = model_seg(m_data, m_ctrl, idx);
    if (we && !addr) begin
      for (int k = 0; k < 4; k++) if (be[k]) m_data[8*k +: 8] = din[8*k +: 8];
    end
    if (we && addr && be[0]) m_ctrl = din[1:0];
    m_cyc++;
    @(negedge Clk);
    WE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    Addr = 1'b0;
    #1;
    vectors++;
    if (TubeSel !== 8'hFF || TubeSeg !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_outputs sel=%h seg=%h want FF/FF", TubeSel, TubeSeg);
    end
    vectors++;
    if (DOut !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0", DOut);
    end
    Addr = 1'b1;
    #1;
    vectors++;
    if (DOut !== 32'd1) begin
      miscompares++;
      $display("FAIL reset_ctrl got %h want 1", DOut);
    end
    Reset = 1'b1;
    model_reset();
    clk_cycle(0, 0, 4'h0, 32'd0);
    vectors++;
    if (TubeSel !== 8'hFE || TubeSeg !== 8'hC0) begin
      miscompares++;
      $display("FAIL first_update sel=%h seg=%h want FE/C0", TubeSel, TubeSeg);
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 40; i++) begin
      clk_cycle(0, 0, 4'h0, 32'd0);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL scan cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
    end
  endtask

  task automatic test_hex_digits();
    clk_cycle(1, 0, 4'hF, 32'h89ABCDEF);
    Addr = 1'b0;
    #1;
    vectors++;
    if (DOut !== 32'h89ABCDEF) begin
      miscompares++;
      $display("FAIL hex_readback got %h want 89ABCDEF", DOut);
    end
    for (int i = 0; i < 34; i++) begin
      clk_cycle(0, 0, 4'h0, 32'd0);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL hex cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
    end
  endtask

  task automatic test_byte_enable();
    clk_cycle(1, 0, 4'hF, 32'h12345678);
    clk_cycle(1, 0, 4'b0100, 32'hFFFFFFFF);
    Addr = 1'b0;
    #1;
    vectors++;
    if (DOut !== 32'h12FF5678) begin
      miscompares++;
      $display("FAIL byte_enable got %h want 12FF5678", DOut);
    end
    vectors++;
    if (DOut !== m_data) begin
      miscompares++;
      $display("FAIL byte_enable_model got %h want %h", DOut, m_data);
    end
  endtask

  task automatic test_lzb();
    clk_cycle(1, 0, 4'hF, 32'h00000A05);
    clk_cycle(1, 1, 4'h1, 32'h3);
    for (int i = 0; i < 34; i++) begin
      clk_cycle(0, 0, 4'h0, 32'd0);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL lzb cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
    end
    clk_cycle(1, 1, 4'h1, 32'h1);
  endtask

  task automatic test_enable_toggle();
    clk_cycle(0, 0, 4'h0, 32'd0);
    clk_cycle(1, 1, 4'h1, 32'h0);
    clk_cycle(0, 0, 4'h0, 32'd0);
    vectors++;
    if (TubeSel !== 8'hFF || TubeSeg !== 8'hFF) begin
      miscompares++;
      $display("FAIL disable sel=%h seg=%h want FF/FF", TubeSel, TubeSeg);
    end
    for (int i = 0; i < 5; i++) clk_cycle(0, 0, 4'h0, 32'd0);
    clk_cycle(1, 1, 4'h1, 32'h1);
    for (int i = 0; i < 12; i++) begin
      clk_cycle(0, 0, 4'h0, 32'd0);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL resume cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_dout;
    for (int i = 0; i < 400; i++) begin
      clk_cycle($urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom), $urandom);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL random cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
      Addr = 1'($urandom);
      #1;
      exp_dout = Addr ? {30'd0, m_ctrl} : m_data;
      vectors++;
      if (DOut !== exp_dout) begin
        miscompares++;
        $display("FAIL random_dout cyc%0d addr=%0d got %h want %h", i, Addr, DOut, exp_dout);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    clk_cycle(1, 0, 4'hF, 32'h5A5A5A5A);
    WE = 1'b1; Addr = 1'b0; BE = 4'hF; DIn = 32'hDEADBEEF;
    #2;
    Reset = 1'b0;
    #1;
    vectors++;
    if (TubeSel !== 8'hFF || TubeSeg !== 8'hFF) begin
      miscompares++;
      $display("FAIL async_reset sel=%h seg=%h want FF/FF", TubeSel, TubeSeg);
    end
    vectors++;
    if (DOut !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset_data got %h want 0", DOut);
    end
    Addr = 1'b1;
    #1;
    vectors++;
    if (DOut !== 32'd1) begin
      miscompares++;
      $display("FAIL async_reset_ctrl got %h want 1", DOut);
    end
    WE = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      clk_cycle(0, 0, 4'h0, 32'd0);
      vectors++;
      if (TubeSel !== exp_sel || TubeSeg !== exp_seg) begin
        miscompares++;
        $display("FAIL post_reset cyc%0d sel=%h seg=%h want %h/%h", i, TubeSel, TubeSeg, exp_sel, exp_seg);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_hex_digits();
    test_byte_enable();
    test_lzb();
    test_enable_toggle();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
